// File: rtl/qed_pkg.sv
// Shared definitions for the QED duplication controller: opcodes, state encoding and the
// register-field remap applied to replayed instructions.
package qed_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [31:0] QED_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ORIG = 2'd0,
    DUP  = 2'd1,
    DONE = 2'd2
  } qed_state_t;

  // x0 stays x0; x1..x15 move to the upper half of the register file.
  function automatic logic [4:0] qed_map_reg(input logic [4:0] f);
    return (f == 5'd0) ? f : (f | 5'b10000);
  endfunction

  function automatic logic [31:0] qed_remap(input logic [31:0] instr);
    logic [6:0]  opc;
    logic        rd_en;
    logic        rs1_en;
    logic        rs2_en;
    logic [31:0] res;
    opc    = instr[6:0];
    rd_en  = opc inside {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR};
    rs1_en = opc inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
    rs2_en = opc inside {OP, STORE, BRANCH};
    res    = instr;
    if (rd_en)  res[11:7]  = qed_map_reg(instr[11:7]);
    if (rs1_en) res[19:15] = qed_map_reg(instr[19:15]);
    if (rs2_en) res[24:20] = qed_map_reg(instr[24:20]);
    return res;
  endfunction

endpackage

// File: rtl/qed_dup_ctrl_if.sv
// Fetch-side and decoder-side signals of the QED duplication controller.
interface qed_dup_ctrl_if #(
  parameter int unsigned IW     = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              ena;
  logic              ifu_vld;
  logic [IW-1:0]     ifu_instr;
  logic              exec_dup;
  logic [IW-1:0]     qed_instr;
  logic              qed_vld;
  logic [ADDR_W:0]   qed_num_orig;
  logic [ADDR_W:0]   qed_num_dup;
  logic              qed_check_valid;
  logic              cache_full;
  logic              cache_empty;
  logic [1:0]        qed_mode;

  modport master (
    output ena, ifu_vld, ifu_instr, exec_dup,
    input  qed_instr, qed_vld, qed_num_orig, qed_num_dup, qed_check_valid,
           cache_full, cache_empty, qed_mode
  );

  modport slave (
    input  ena, ifu_vld, ifu_instr, exec_dup,
    output qed_instr, qed_vld, qed_num_orig, qed_num_dup, qed_check_valid,
           cache_full, cache_empty, qed_mode
  );
endinterface

// File: rtl/qed_i_cache.sv
// DEPTH-entry instruction FIFO recording originals for later replay; synchronous clear.
module qed_i_cache #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IW     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [IW-1:0]     wdata_i,
  output logic [IW-1:0]     rdata_o,
  output logic [ADDR_W:0]   occ_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   OneCnt   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] OnePtr   = {{(ADDR_W - 1){1'b0}}, 1'b1};

  logic [IW-1:0]     mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   occ_q, occ_d;

  // Pointers are exactly ADDR_W bits wide, so the increment wraps mod DEPTH.
  always_comb begin
    head_d = pop_i  ? head_q + OnePtr : head_q;
    tail_d = push_i ? tail_q + OnePtr : tail_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + OneCnt;
      2'b01:   occ_d = occ_q - OneCnt;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_i) mem_q[tail_q] <= wdata_i;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign occ_o   = occ_q;
  assign full_o  = (occ_q == DepthCnt);
  assign empty_o = (occ_q == '0);

endmodule

// File: rtl/qed_dup_ctrl.sv
// QED duplication controller: passes originals through while caching them, then replays
// them with remapped registers so the consistency check can compare both halves.
module qed_dup_ctrl
  import qed_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IW     = 32
) (
  input logic          clk,
  input logic          rst,
  qed_dup_ctrl_if.slave bus
);
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] OneCnt   = {{ADDR_W{1'b0}}, 1'b1};

  qed_state_t      state_q, state_d;
  logic [ADDR_W:0] num_orig_q, num_orig_d;
  logic [ADDR_W:0] num_dup_q, num_dup_d;
  logic            check_valid_q, check_valid_d;

  logic            push;
  logic            pop;
  logic [IW-1:0]   cache_rdata;
  logic [ADDR_W:0] occ;
  logic [ADDR_W:0] occ_nxt;
  logic            full;
  logic            empty;

  assign push    = (state_q == ORIG) && bus.ena && bus.ifu_vld && !full;
  assign pop     = (state_q == DUP) && bus.ena;
  assign occ_nxt = occ + {{ADDR_W{1'b0}}, push};

  qed_i_cache #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IW     (IW)
  ) u_cache (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.ifu_instr),
    .rdata_o (cache_rdata),
    .occ_o   (occ),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d       = state_q;
    num_orig_d    = push ? num_orig_q + OneCnt : num_orig_q;
    num_dup_d     = pop  ? num_dup_q + OneCnt  : num_dup_q;
    check_valid_d = (state_q == DONE) && (num_orig_q == num_dup_q);
    unique case (state_q)
      // A full cache forces replay even without a request.
      ORIG: if (bus.ena && ((bus.exec_dup && occ_nxt != '0) || occ_nxt == DepthCnt)) begin
        state_d = DUP;
      end
      DUP:  if (pop && occ == OneCnt) state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = ORIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ORIG;
      num_orig_q    <= '0;
      num_dup_q     <= '0;
      check_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_orig_q    <= num_orig_d;
      num_dup_q     <= num_dup_d;
      check_valid_q <= check_valid_d;
    end
  end

  always_comb begin
    bus.qed_instr = QED_NOP;
    bus.qed_vld   = 1'b1;
    unique case (state_q)
      ORIG: begin
        bus.qed_instr = bus.ifu_instr;
        bus.qed_vld   = bus.ifu_vld;
      end
      DUP:     bus.qed_instr = qed_remap(cache_rdata);
      default: bus.qed_instr = QED_NOP;
    endcase
  end

  assign bus.qed_num_orig    = num_orig_q;
  assign bus.qed_num_dup     = num_dup_q;
  assign bus.qed_check_valid = check_valid_q;
  assign bus.cache_full      = full;
  assign bus.cache_empty     = empty;
  assign bus.qed_mode        = state_q;

endmodule

// File: doc/qed_dup_ctrl.md
Name: qed_dup_ctrl

Overview:
- QED instruction-duplication controller; sits between the instruction fetch path and the core decoder, ahead of the QED consistency check.
- ORIG mode: passes original instructions through unchanged and records each one in an internal cache.
- DUP mode: replays the cached instructions with register fields remapped x1..x15 -> x17..x31.
- Produces qed_num_orig, qed_num_dup and qed_check_valid, which the consistency check samples at commit.

Parameters:
- DEPTH, 16, instruction cache entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).
- IW, 32, instruction width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- ena  in  1  core accepts qed_instr this cycle (stall_n)
- ifu_vld  in  1  ifu_instr is valid
- ifu_instr  in  IW  fetched instruction (already constrained to allowed opcodes, regs x0..x15)
- exec_dup  in  1  free/symbolic request to switch to DUP mode
- qed_instr  out  IW  instruction to decoder
- qed_vld  out  1  qed_instr valid
- qed_num_orig  out  ADDR_W+1  originals issued
- qed_num_dup  out  ADDR_W+1  duplicates issued
- qed_check_valid  out  1  registered; counts equal and replay done
- cache_full  out  1  cache occupancy == DEPTH
- cache_empty  out  1  cache occupancy == 0
- qed_mode  out  2  current state encoding

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=ORIG; head=tail=0; occupancy=0; qed_num_orig=qed_num_dup=0; qed_check_valid=0.
  - Cache contents cleared to 0.
  - Reset applies from any state, including mid-DUP; no in-flight replay survives.
- States:
  - ORIG (0): qed_instr=ifu_instr; qed_vld=ifu_vld.
    - Push condition: ena && ifu_vld && !cache_full. On push: cache[tail]<=ifu_instr; tail++ (wraps mod DEPTH); qed_num_orig++.
    - ORIG->DUP when (exec_dup && occupancy_next>0) or occupancy_next==DEPTH (forced). occupancy_next includes the same-cycle push.
    - exec_dup with an empty cache and no push is ignored; state stays ORIG.
  - DUP (1): qed_instr=remap(cache[head]); qed_vld=1; ifu_instr is ignored.
    - Pop condition: ena. On pop: head++ (wraps); qed_num_dup++.
    - DUP->DONE on the pop that makes occupancy 0.
  - DONE (2): qed_instr=NOP (0x00000013); qed_vld=1; no pushes or pops; state held until reset.
- qed_check_valid: set the cycle after entering DONE when qed_num_orig==qed_num_dup; held high in DONE.
- ena low in any state: no push or pop, counters frozen, outputs stable.
- Combinational latency: ifu_instr/cache -> qed_instr is 0 cycles. Counters, flags and state update at the posedge following acceptance.
- remap(i), applied per field:
  - A field f in 1..15 becomes f|16. Field 0 (x0) is never changed.
  - rd[11:7] for R, I, U, J types and LOAD.
  - rs1[19:15] for R, I, S, B types, LOAD, JALR.
  - rs2[24:20] for R, S, B types.
  - Opcodes not in the package list pass through unchanged.
- Counters never wrap: qed_num_orig is at most DEPTH because the full cache forces DUP; qed_num_dup is at most qed_num_orig.

Decomposition:
- Package qed_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - QED_NOP=32'h00000013;
  - typedef enum logic[1:0] qed_state_t {ORIG, DUP, DONE};
  - the remap function.
- Sub-module qed_i_cache: DEPTH-entry FIFO with push/pop, head/tail pointers, occupancy, full/empty. Synchronous active-low clear.

Test Plan:
- Reset, push ADD x3,x1,x2 (0x002081B3) with ena=1, then exec_dup=1 -> ORIG outputs 0x002081B3; DUP outputs 0x012889B3; on pop qed_num_orig=qed_num_dup=1, DONE; qed_check_valid=1 the following cycle.
- Push ADDI x5,x0,7 (0x00700293), DUP -> qed_instr=0x00700A93 (rs1 x0 kept); LUI x7 (0x000013B7) -> 0x00001BB7.
- 16 pushes, exec_dup=0 -> cache_full=1 after the 16th; forced DUP next cycle; 16 replays in order; qed_num_dup=16; DONE.
- exec_dup=1 right after reset with ifu_vld=0 -> stays ORIG, counters 0, cache_empty=1.
- In DUP with 3 cached entries, hold ena=0 for 4 cycles -> qed_instr constant, head and qed_num_dup unchanged; resumes correctly when ena=1.
- rst=0 mid-DUP (2 of 5 replayed) -> next cycle ORIG, counters 0, cache_empty=1, qed_check_valid=0.
